// File: rtl/alu_arbiter_pkg.sv
// alu_pkg: shared ALU op encodings, arbiter FSM states and op legality helper
package alu_pkg;
  localparam int ALU_W = 32;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  function automatic logic is_legal_op(input logic [2:0] op);
    return op != 3'b011 && op != 3'b111;
  endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, ALU and response signals of the shared ALU arbiter
interface alu_arbiter_if #(
  parameter int NREQ = 2,
  parameter int W    = alu_pkg::ALU_W
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic [2:0]        alu_op;
  logic [W-1:0]      alu_a;
  logic [W-1:0]      alu_b;
  logic [W-1:0]      alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
    output req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, rsp_err
  );
  modport master (
    output req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
    input  req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first set request at or after ptr_i
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o
);
  // scan from the farthest offset back so the nearest hit to ptr_i wins
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % NREQ]) begin
        grant_o = '0;
        grant_o[(int'(ptr_i) + k) % NREQ] = 1'b1;
        idx_o = IW'((int'(ptr_i) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU datapath among NREQ requesters, round-robin, one op in flight
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int W       = ALU_W,
  parameter int MUL_LAT = 3
) (
  input logic clk,
  input logic rst_n,
  alu_arbiter_if.slave bus
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = MUL_LAT > 1 ? $clog2(MUL_LAT) : 1;
  state_e state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, id_q, id_d, gidx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d, w_op;
  logic [W-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic err_q, err_d;
  logic [NREQ-1:0] grant;
  logic idle, exec, resp, legal;
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req_i  (bus.req_valid),
    .ptr_i  (rr_q),
    .grant_o(grant),
    .idx_o  (gidx)
  );
  assign idle  = state_q == IDLE;
  assign exec  = state_q == EXEC;
  assign resp  = state_q == RESP;
  assign legal = is_legal_op(op_q);
  assign w_op  = bus.req_op[3*gidx +: 3];
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    err_d   = err_q;
    if (idle && |bus.req_valid) begin
      state_d = EXEC;
      op_d    = w_op;
      a_d     = bus.req_a[W*gidx +: W];
      b_d     = bus.req_b[W*gidx +: W];
      id_d    = gidx;
      rr_d    = (int'(gidx) == NREQ - 1) ? '0 : gidx + IW'(1);
      cnt_d   = (w_op == ALU_MUL) ? CW'(MUL_LAT - 1) : '0;
    end else if (exec && (!legal || cnt_q == '0)) begin
      state_d = RESP;
      data_d  = legal ? bus.alu_result : '0;
      err_d   = !legal;
    end else if (exec) begin
      cnt_d = cnt_q - CW'(1);
    end else if (resp && bus.rsp_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end
  // outputs are gated by state so every idle field reads zero
  assign bus.req_ready = idle ? grant : '0;
  assign bus.alu_op    = exec ? op_q : '0;
  assign bus.alu_a     = exec ? a_q : '0;
  assign bus.alu_b     = exec ? b_q : '0;
  assign bus.rsp_valid = resp;
  assign bus.rsp_id    = resp ? id_q : '0;
  assign bus.rsp_data  = resp ? data_q : '0;
  assign bus.rsp_err   = resp & err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a job-level model
module tb_alu_arbiter;
  import alu_pkg::*;
  localparam int NREQ = 2, W = 32, MUL_LAT = 3, IW = 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();
  alu_arbiter #(.NREQ(NREQ), .W(W), .MUL_LAT(MUL_LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [NREQ-1:0] v = '0;
  logic [2:0] op[NREQ];
  logic [W-1:0] a[NREQ], b[NREQ];
  assign bus.req_valid = v;
  for (genvar g = 0; g < NREQ; g++) begin : pk
    assign bus.req_op[3*g +: 3] = op[g];
    assign bus.req_a[W*g +: W]  = a[g];
    assign bus.req_b[W*g +: W]  = b[g];
  end
  int vectors = 0, miscmp = 0;
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] alu_fn(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      3'b000:  return x + y;
      3'b001:  return x - y;
      3'b010:  return x * y;
      3'b100:  return x << y[4:0];
      3'b101:  return x & y;
      3'b110:  return x >> y[4:0];
      default: return 32'hA5A5A5A5;
    endcase
  endfunction
  function automatic logic legal(input logic [2:0] o);
    return o != 3'b011 && o != 3'b111;
  endfunction
  function automatic int lat(input logic [2:0] o);
    return o == 3'b010 ? MUL_LAT : 1;
  endfunction
  function automatic logic [127:0] pack(input logic [NREQ-1:0] r, input logic [2:0] o, input logic [W-1:0] x,
                                        input logic [W-1:0] y, input logic rv, input logic [IW-1:0] id,
                                        input logic [W-1:0] d, input logic e);
    return {r, o, x, y, rv, id, d, e};
  endfunction
  function automatic logic [127:0] outs();
    return pack(bus.req_ready, bus.alu_op, bus.alu_a, bus.alu_b, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err);
  endfunction
  // ALU stand-in: the product is garbage until the operands have been held MUL_LAT cycles
  int mul_age = 0;
  always @(posedge clk) mul_age <= (bus.alu_op == ALU_MUL) ? mul_age + 1 : 0;
  assign bus.alu_result = (bus.alu_op == ALU_MUL && mul_age < MUL_LAT - 1) ? 32'hDEADBEEF
                                                                           : alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
  int act = 0, age = 0, nxt = 0, jid = 0, w;
  logic [2:0] jop;
  logic [W-1:0] ja, jb;
  logic [NREQ-1:0] er;
  logic [127:0] ev;
  always @(negedge clk) begin
    if (!rst_n) begin
      act = 0;
      nxt = 0;
      check("reset_outs", outs(), '0);
    end else begin
      er = '0;
      w = -1;
      if (act == 0)
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && v[(nxt + k) % NREQ]) w = (nxt + k) % NREQ;
      if (w >= 0) er[w] = 1'b1;
      if (act == 0) ev = pack(er, '0, '0, '0, 1'b0, '0, '0, 1'b0);
      else if (age <= lat(jop)) ev = pack('0, jop, ja, jb, 1'b0, '0, '0, 1'b0);
      else ev = pack('0, '0, '0, '0, 1'b1, IW'(jid), legal(jop) ? alu_fn(jop, ja, jb) : '0, !legal(jop));
      check("cycle", outs(), ev);
      if (act == 0 && w >= 0) begin
        act = 1;
        age = 1;
        jid = w;
        jop = op[w];
        ja  = a[w];
        jb  = b[w];
        nxt = (w + 1) % NREQ;
      end else if (act != 0) begin
        if (age > lat(jop) && bus.rsp_ready) act = 0;
        else age++;
      end
    end
  end
  task automatic run(input int i, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     input int elat, input logic [W-1:0] ed, input logic ee);
    int n, ex;
    v[i] = 1'b1; op[i] = o; a[i] = x; b[i] = y;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.req_ready[i] && n < 20);
    check("grant_wait", n, 1);
    @(posedge clk); #1 v[i] = 1'b0;
    n = 0; ex = 0;
    do begin
      @(negedge clk); n++;
      if (bus.alu_op == o && bus.alu_a == x && bus.alu_b == y && !bus.rsp_valid) ex++;
    end while (!bus.rsp_valid && n < 20);
    check("rsp_latency", n, elat);
    check("exec_cycles", ex, elat - 1);
    check("rsp_fields", {bus.rsp_id, bus.rsp_data, bus.rsp_err}, {IW'(i), ed, ee});
    @(posedge clk); #1;
  endtask
  logic [NREQ-1:0] g;
  int gl[$];
  int n;
  initial begin
    for (int i = 0; i < NREQ; i++) begin op[i] = '0; a[i] = '0; b[i] = '0; end
    bus.rsp_ready = 1'b1;
    #3 check("reset_zero", outs(), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run(0, ALU_ADD, 5, 7, 2, 12, 1'b0);
    run(1, ALU_MUL, 6, 7, 4, 42, 1'b0);
    v = '1;
    op[0] = ALU_ADD; a[0] = 1; b[0] = 1;
    op[1] = ALU_SUB; a[1] = 10; b[1] = 3;
    n = 0;
    while (gl.size() < 4 && n < 60) begin
      @(negedge clk); n++;
      if (bus.req_ready[0]) gl.push_back(0);
      else if (bus.req_ready[1]) gl.push_back(1);
    end
    @(posedge clk); #1 v = '0;
    check("alt_count", gl.size(), 4);
    foreach (gl[k]) check("alt_grant", gl[k], k % 2);
    repeat (4) @(posedge clk);
    #1;
    run(0, 3'b111, 3, 4, 2, 0, 1'b1);
    run(1, ALU_SUB, 9, 4, 2, 5, 1'b0);
    bus.rsp_ready = 1'b0;
    run(0, ALU_AND, 32'hF0F0, 32'hFF00, 2, 32'hF000, 1'b0);
    v[1] = 1'b1; op[1] = ALU_SLL; a[1] = 3; b[1] = 4;
    repeat (4) begin
      @(negedge clk); check("hold_rsp", outs(), pack('0, '0, '0, '0, 1'b1, '0, 32'hF000, 1'b0));
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk); check("hold_rsp", outs(), pack('0, '0, '0, '0, 1'b1, '0, 32'hF000, 1'b0));
    @(posedge clk); #1;
    run(1, ALU_SLL, 3, 4, 2, 48, 1'b0);
    v[0] = 1'b1; op[0] = ALU_MUL; a[0] = 100; b[0] = 200;
    @(negedge clk); check("mul_grant", bus.req_ready, 2'b01);
    @(posedge clk); #1 v[0] = 1'b0;
    @(negedge clk); check("mul_exec", bus.alu_op, ALU_MUL);
    #1 rst_n = 1'b0;
    #1 check("reset_async", outs(), '0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    n = 0;
    repeat (3) begin @(negedge clk); if (bus.rsp_valid) n++; end
    check("no_rsp_after_reset", n, 0);
    @(posedge clk); #1;
    v = '1; op[0] = ALU_ADD; op[1] = ALU_ADD;
    @(negedge clk); check("grant_after_reset", bus.req_ready, 2'b01);
    @(posedge clk); #1 v = '0;
    repeat (4) @(posedge clk);
    #1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); g = bus.req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (v[i] && g[i]) v[i] = 1'b0;
        else if (v[i] && $urandom_range(0, 40) == 0) v[i] = 1'b0;
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          op[i] = 3'($urandom_range(0, 7));
          a[i] = $urandom;
          b[i] = $urandom;
        end
      end
      bus.rsp_ready = $urandom_range(0, 3) != 0;
    end
    v = '0;
    bus.rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end
endmodule
